// File: rtl/decomp_pkg.sv
// Shared types and helpers for the decompressor dictionary.
package decomp_pkg;

    localparam int unsigned DEF_DATA_WIDTH      = 32;
    localparam int unsigned DEF_WORDS_PER_ENTRY = 16;

    typedef enum logic [2:0] {
        ZZZZ = 3'd0,
        XXXX = 3'd1,
        MMMM = 3'd2,
        MMXX = 3'd3,
        ZZZX = 3'd4,
        MMMX = 3'd5,
        RSV6 = 3'd6,
        RSV7 = 3'd7
    } code_e;

    function automatic logic is_push(code_e c);
        return (c == XXXX) || (c == MMXX) || (c == MMMX);
    endfunction

    function automatic logic is_match(code_e c);
        return (c == MMMM) || (c == MMXX) || (c == MMMX);
    endfunction

endpackage

// File: rtl/decomp_word_build.sv
// Rebuilds one 32-bit word from a match code, the dictionary word it refers to and literal bits.
module decomp_word_build
    import decomp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic [2:0]            code,
    input  logic [DATA_WIDTH-1:0] dict_word,
    input  logic [DATA_WIDTH-1:0] lit,
    output logic [DATA_WIDTH-1:0] word_c
);

    localparam int unsigned HALF   = DATA_WIDTH / 2;
    localparam int unsigned BYTE_W = 8;

    always_comb begin
        word_c = '0;
        case (code_e'(code))
            XXXX:    word_c = lit;
            MMMM:    word_c = dict_word;
            MMXX:    word_c = {dict_word[DATA_WIDTH-1:HALF], lit[HALF-1:0]};
            ZZZX:    word_c = {{(DATA_WIDTH-BYTE_W){1'b0}}, lit[BYTE_W-1:0]};
            MMMX:    word_c = {dict_word[DATA_WIDTH-1:BYTE_W], lit[BYTE_W-1:0]};
            default: word_c = '0;
        endcase
    end

endmodule

// File: rtl/decomp_dict.sv
// Two-lane token decoder with a 16-entry dictionary kept in lock-step with the compressor.
// Optional DICT_HIT_CHECK_EN adds per-entry valid bits and a sticky o_err flag.
module decomp_dict
    import decomp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int unsigned WORDS_PER_ENTRY = DEF_WORDS_PER_ENTRY,
    localparam int unsigned IDX_W          = $clog2(WORDS_PER_ENTRY)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  in_valid,
    input  logic                  in_valid2,
    output logic                  in_ready,
    input  logic [2:0]            code,
    input  logic [2:0]            code2,
    input  logic [IDX_W-1:0]      idx,
    input  logic [IDX_W-1:0]      idx2,
    input  logic [DATA_WIDTH-1:0] lit,
    input  logic [DATA_WIDTH-1:0] lit2,
    output logic                  out_valid,
    output logic                  out_valid2,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [DATA_WIDTH-1:0] out_data2
`ifdef DICT_HIT_CHECK_EN
    ,
    output logic                  o_err
`endif
);

    logic [DATA_WIDTH-1:0] dict [WORDS_PER_ENTRY];
    logic [IDX_W-1:0]      ptr;

    code_e                 c0, c1;
    logic                  accept, accept2, push0, push1, fwd1;
    logic [IDX_W-1:0]      wslot1;
    logic [DATA_WIDTH-1:0] rd0, rd1, word0, word1;

    assign c0       = code_e'(code);
    assign c1       = code_e'(code2);
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign accept2  = accept && in_valid2;
    assign push0    = accept && is_push(c0);
    assign push1    = accept2 && is_push(c1);
    assign wslot1   = push0 ? ptr + IDX_W'(1) : ptr;

    // Lane 1 sees lane 0's same-cycle push when it reads that slot.
    assign fwd1 = push0 && (idx2 == ptr);
    assign rd0  = dict[idx];
    assign rd1  = fwd1 ? word0 : dict[idx2];

    decomp_word_build #(.DATA_WIDTH(DATA_WIDTH)) u_build0 (
        .code      (code),
        .dict_word (rd0),
        .lit       (lit),
        .word_c    (word0)
    );

    decomp_word_build #(.DATA_WIDTH(DATA_WIDTH)) u_build1 (
        .code      (code2),
        .dict_word (rd1),
        .lit       (lit2),
        .word_c    (word1)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < int'(WORDS_PER_ENTRY); i++) dict[i] <= '0;
            ptr <= '0;
        end else begin
            if (push0) dict[ptr]    <= word0;
            if (push1) dict[wslot1] <= word1;
            ptr <= ptr + IDX_W'(push0) + IDX_W'(push1);
        end
    end

    // Output stage: loads whenever downstream is free, holds otherwise.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            out_valid  <= 1'b0;
            out_valid2 <= 1'b0;
            out_data   <= '0;
            out_data2  <= '0;
        end else if (in_ready) begin
            out_valid  <= accept;
            out_valid2 <= accept2;
            if (accept)  out_data  <= word0;
            if (accept2) out_data2 <= word1;
        end
    end

`ifdef DICT_HIT_CHECK_EN
    logic [WORDS_PER_ENTRY-1:0] vld;
    logic                       bad0_c, bad1_c;

    always_comb begin
        bad0_c = accept &&
                 ((is_match(c0) && !vld[idx]) || (c0 == RSV6) || (c0 == RSV7));
        bad1_c = accept2 &&
                 ((is_match(c1) && !(fwd1 || vld[idx2])) || (c1 == RSV6) || (c1 == RSV7));
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            vld   <= '0;
            o_err <= 1'b0;
        end else begin
            if (push0) vld[ptr]    <= 1'b1;
            if (push1) vld[wslot1] <= 1'b1;
            o_err <= o_err || bad0_c || bad1_c;
        end
    end
`endif

endmodule
